// File: rtl/simon_pkg.sv
// Shared constants and FSM state type for the SIMON64/128 key-schedule controller.
package simon_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ROUNDS    = 44;
  localparam int unsigned KEY_WORDS = 4;
  localparam int unsigned ADDR_W    = 6;

  // Leftmost character of the z3 string is Z3[61], i.e. sequence index 0.
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  function automatic logic z3_bit(input logic [5:0] j);
    return Z3[6'd61 - j];
  endfunction

endpackage

// File: rtl/simon_key_sched_ctrl_keybox.sv
// One SIMON64/128 key-expansion step (m=4): produces k[i+4] from k[i+3], k[i+1], k[i].
module keyBox (
  input  logic [31:0] Ki3,
  input  logic [31:0] Ki1,
  input  logic [31:0] Ki,
  input  logic [31:0] zj,
  output logic [31:0] Ki4
);

  logic [31:0] w_t1;
  logic [31:0] w_t2;

  assign w_t1 = {Ki3[2:0], Ki3[31:3]} ^ Ki1;
  assign w_t2 = w_t1 ^ {w_t1[0], w_t1[31:1]};
  // ~Ki ^ 3 is Ki ^ c with c = 2^32 - 4.
  assign Ki4  = ~Ki ^ w_t2 ^ zj ^ 32'd3;

endmodule

// File: rtl/simon_key_sched_ctrl.sv
// Expands a 128-bit master key into 44 round keys, stores them, and serves
// them through a registered read port that is usable while expansion runs.
module simon_key_sched_ctrl
  import simon_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WORD_W*KEY_WORDS-1:0] key_in,
  input  logic                        key_valid,
  output logic                        key_ready,
  output logic                        busy,
  output logic                        keys_valid,
  input  logic                        rd_en,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic                        rd_valid,
  output logic [WORD_W-1:0]           rd_data,
  output logic                        rd_err
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WORD_W-1:0]  r_bank [ROUNDS];
  logic [WORD_W-1:0]  r_w    [KEY_WORDS];
  logic [5:0]         r_i;
  logic [ADDR_W-1:0]  r_gen_cnt;
  logic               r_rd_valid;
  logic [WORD_W-1:0]  r_rd_data;
  logic               r_rd_err;
  logic               w_accept;
  logic [WORD_W-1:0]  w_new;
  logic [WORD_W-1:0]  w_zj;

  assign w_zj = {{(WORD_W-1){1'b0}}, z3_bit(r_i)};

  keyBox u_keybox (
    .Ki3 (r_w[3]),
    .Ki1 (r_w[1]),
    .Ki  (r_w[0]),
    .zj  (w_zj),
    .Ki4 (w_new)
  );

  always_comb begin
    w_state_nxt = r_state;
    key_ready   = 1'b0;
    busy        = 1'b0;
    keys_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) w_state_nxt = EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (r_i == 6'(ROUNDS - KEY_WORDS - 1)) w_state_nxt = DONE;
      end
      DONE: begin
        key_ready  = 1'b1;
        keys_valid = 1'b1;
        if (key_valid) w_state_nxt = EXPAND;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = key_valid && key_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < ROUNDS; k++) r_bank[k] <= '0;
      for (int unsigned k = 0; k < KEY_WORDS; k++) r_w[k] <= '0;
      r_i       <= '0;
      r_gen_cnt <= '0;
    end else if (w_accept) begin
      for (int unsigned k = 0; k < KEY_WORDS; k++) begin
        r_bank[k] <= key_in[k*WORD_W +: WORD_W];
        r_w[k]    <= key_in[k*WORD_W +: WORD_W];
      end
      r_i       <= '0;
      r_gen_cnt <= ADDR_W'(KEY_WORDS);
    end else if (r_state == EXPAND) begin
      r_bank[r_i + 6'(KEY_WORDS)] <= w_new;
      r_w[0] <= r_w[1];
      r_w[1] <= r_w[2];
      r_w[2] <= r_w[3];
      r_w[3] <= w_new;
      r_i    <= r_i + 6'd1;
      if (r_gen_cnt < ADDR_W'(ROUNDS)) r_gen_cnt <= r_gen_cnt + 1'b1;
    end
  end

  // gen_cnt never exceeds ROUNDS, so the range test also rejects addresses >= 44.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        if (rd_addr < r_gen_cnt) begin
          r_rd_data <= r_bank[rd_addr];
          r_rd_err  <= 1'b0;
        end else begin
          r_rd_data <= '0;
          r_rd_err  <= 1'b1;
        end
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_err   = r_rd_err;

endmodule

// File: doc/simon_key_sched_ctrl.md
Name: simon_key_sched_ctrl

Overview:
- Sequences the existing SIMON64/128 key-expansion step (`keyBox`) to expand a 128-bit master key into all 44 32-bit round keys.
- Stores the round keys in a 44-entry register bank and serves them through a 1-cycle-latency read port.
- Sits between the key-load interface and the round datapath. Rounds may start reading keys while expansion is still running.

Parameters:
- WORD_W, 32, round-key word width in bits.
- ROUNDS, 44, number of round keys stored.
- KEY_WORDS, 4, master-key words (m).
- ADDR_W, 6, round-key address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_in  in  128  master key; key_in[31:0] is k0, key_in[127:96] is k3.
- key_valid  in  1  key_in is valid.
- key_ready  out  1  controller can accept a key.
- busy  out  1  expansion in progress.
- keys_valid  out  1  all 44 round keys are valid.
- rd_en  in  1  round-key read request.
- rd_addr  in  ADDR_W  round-key index, 0..43.
- rd_valid  out  1  rd_data/rd_err are valid this cycle.
- rd_data  out  WORD_W  round key k[rd_addr].
- rd_err  out  1  address is out of range or the key is not yet generated.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset:
  - State goes to IDLE; the counter, window registers and key bank are cleared to 0.
  - Output reset values: key_ready=1 (from the first post-reset cycle), busy=0, keys_valid=0, rd_valid=0, rd_data=0, rd_err=0.
  - Reset asserted mid-expansion aborts the expansion immediately; no partial keys remain valid.
- FSM states: IDLE, EXPAND, DONE.
- IDLE: key_ready=1. A key is accepted when key_valid && key_ready.
- On key acceptance (cycle N):
  - bank[0..3] <= k0..k3.
  - Window w0..w3 <= k0..k3.
  - gen_cnt <= 4, i <= 0, keys_valid <= 0.
  - State goes to EXPAND.
- EXPAND (cycles N+1 .. N+40): key_ready=0, busy=1. Each cycle:
  - new = keyBox(Ki3=w3, Ki1=w1, Ki=w0, zj={31'b0, Z3[i]}).
  - bank[i+4] <= new.
  - Window shifts: w0<=w1, w1<=w2, w2<=w3, w3<=new.
  - i++, gen_cnt++.
  - After the cycle where i==39, state goes to DONE.
- Z3 indexing: Z3[j] is the j-th bit counted from the leftmost character of the 62-bit SIMON z3 string. Only j=0..39 are used, so no mod-62 wrap is needed; the index width must still hold 0..61.
- DONE: keys_valid=1, busy=0, key_ready=1.
  - A new key accepted in DONE clears keys_valid in the same edge and restarts at EXPAND.
  - The bank is overwritten progressively; gen_cnt resets to 4, so reads of indices >= 4 error until regenerated.
- Read port:
  - rd_en at cycle T gives rd_valid=1 at T+1.
  - If rd_addr < gen_cnt (sampled at T): rd_data=bank[rd_addr], rd_err=0.
  - Otherwise (including rd_addr >= 44): rd_data=0, rd_err=1.
  - A key written at edge T is readable by a request issued at T+1. There is no same-cycle write-to-read bypass.
  - Reads are allowed in every state. A read at the key-acceptance cycle sees the old gen_cnt.
  - rd_valid=0 when rd_en was 0; rd_data and rd_err hold their last values.
- key_valid while key_ready=0 is ignored (not queued). key_in must be held until accepted.
- Width rules: all XOR and rotate operations are inside `keyBox`. gen_cnt saturates at 44.
- Total latency: key accepted at N, keys_valid=1 at N+41.

Decomposition:
- Package simon_pkg holds:
  - WORD_W, ROUNDS, KEY_WORDS, ADDR_W.
  - The 62-bit constant Z3 = 11011011101011000110010111100000010010001010011100110100001111.
  - The FSM state enum (IDLE, EXPAND, DONE).
- One sub-module: the existing `keyBox`, instantiated once, unmodified, as the combinational step.
- FSM, window, bank and read port stay in this module.

Test Plan:
- Reset, then key_in=1b1a1918_13121110_0b0a0908_03020100 with key_valid for one cycle:
  - key_ready drops at N+1; keys_valid rises exactly at N+41.
  - Reads of 0..3 return 03020100, 0b0a0908, 13121110, 1b1a1918.
  - Reads of 4..43 match the golden SIMON64/128 model; encrypting plaintext 656b696c_20646e75 with the model's keys gives 44c8fc20_b9dfa07a.
- Overlapped read: at N+2 read rd_addr=4 -> rd_valid at N+3 with the correct k4, rd_err=0. At N+2 read rd_addr=10 -> rd_err=1, rd_data=0.
- Out of range: after DONE, rd_addr=44 and rd_addr=63 -> rd_err=1, rd_data=0. rd_addr=43 -> valid k43.
- Key offered while busy: key_valid with a different key at N+5 -> ignored. Final bank equals the first key's expansion and keys_valid timing is unchanged.
- Reset mid-expansion: rst at N+20 -> busy=0, key_ready=1, keys_valid=0 next cycle, and a read of index 2 returns rd_err=1.
- Back-to-back keys: key A, then key B accepted in DONE -> keys_valid drops, reads of index 10 error until regenerated, and the final bank matches key B's golden expansion.
